// File: rtl/bus_slave_decoder.sv
// Master-side request decoder for the four-slave DLX data bus: one request at a
// time, one-hot slave strobe from addr[31:30], four-phase ack or timeout bus error.
module bus_slave_decoder #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_req,
    input  logic        m_wr,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_ack,
    output logic        m_err,
    output logic [1:0]  s_sel,
    output logic [3:0]  s_strb,
    output logic        s_wr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [3:0]  s_ack,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Counter value seen on the last permitted strobe cycle.
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_sel;
    logic [3:0]  r_strb;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_ack;
    logic        r_err;
    logic        w_sel_ack;

    // Only the selected slave's acknowledge is ever looked at.
    assign w_sel_ack = s_ack[r_sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_sel   <= 2'd0;
            r_strb  <= 4'd0;
            r_wr    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m_req) begin
                        r_addr  <= m_addr;
                        r_wdata <= m_wdata;
                        r_wr    <= m_wr;
                        r_sel   <= m_addr[31:30];
                        r_strb  <= 4'b0001 << m_addr[31:30];
                        r_cnt   <= 8'd0;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (w_sel_ack) begin
                        r_strb  <= 4'd0;
                        r_ack   <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (r_cnt == LP_LAST) begin
                        r_strb  <= 4'd0;
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (!m_req) begin
                        r_ack   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_strb  <= 4'd0;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ack     = r_ack;
    assign m_err     = r_err;
    assign s_sel     = r_sel;
    assign s_strb    = r_strb;
    assign s_wr      = r_wr;
    assign s_addr    = r_addr;
    assign s_wdata   = r_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_slave_decoder.sv
// Self-checking bench for bus_slave_decoder: directed scenarios plus random
// transactions checked against a transaction-level slave/timeout model.
module tb_bus_slave_decoder;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_req;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic        m_err;
    logic [1:0]  s_sel;
    logic [3:0]  s_strb;
    logic        s_wr;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_ack;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    bus_slave_decoder #(.TIMEOUT(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .s_sel     (s_sel),
        .s_strb    (s_strb),
        .s_wr      (s_wr),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_ack     (s_ack),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Runs one transaction. ack_at = k: the selected slave raises ack so that it
    // is sampled at strobe edge k (0 = never). noise: non-selected slaves ack.
    // drop_early: master lowers m_req during the first strobe cycle.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int ack_at, input bit noise, input bit drop_early,
                           input string name);
        logic [1:0] sel;
        logic [3:0] oh;
        int exp_cycles;
        bit exp_err;
        int strobe_cycles;
        int ack_idx;
        int hold;
        sel = addr[31:30];
        oh  = 4'b0001 << sel;
        if (ack_at >= 1 && ack_at <= T) begin
            exp_cycles = ack_at;
            exp_err    = 1'b0;
        end else begin
            exp_cycles = T;
            exp_err    = 1'b1;
        end
        @(negedge clk);
        m_req   = 1'b1;
        m_addr  = addr;
        m_wr    = wr;
        m_wdata = wdata;
        s_ack   = noise ? (~oh & 4'hF) : 4'h0;
        strobe_cycles = 0;
        ack_idx = 0;
        for (int n = 1; n <= T + 5; n++) begin
            @(negedge clk);
            if (m_ack) begin
                ack_idx = n;
                break;
            end
            total++;
            if (s_strb !== oh) begin
                bad++;
                $display("FAIL %s strobe idx=%0d got=%b exp=%b", name, n, s_strb, oh);
            end
            strobe_cycles++;
            total++;
            if ({s_sel, s_wr, s_addr, s_wdata} !== {sel, wr, addr, wdata}) begin
                bad++;
                $display("FAIL %s latch idx=%0d got sel=%0d wr=%b a=%h d=%h exp sel=%0d wr=%b a=%h d=%h",
                         name, n, s_sel, s_wr, s_addr, s_wdata, sel, wr, addr, wdata);
            end
            if (n == ack_at) s_ack[sel] = 1'b1;
            if (drop_early && n == 1) m_req = 1'b0;
            m_addr  = $urandom;
            m_wdata = $urandom;
            m_wr    = 1'($urandom_range(0, 1));
        end
        total++;
        if (ack_idx == 0) begin
            bad++;
            $display("FAIL %s no_ack got=0 exp=1", name);
        end
        total++;
        if (strobe_cycles != exp_cycles) begin
            bad++;
            $display("FAIL %s strobe_len got=%0d exp=%0d", name, strobe_cycles, exp_cycles);
        end
        total++;
        if (m_err !== exp_err) begin
            bad++;
            $display("FAIL %s err got=%b exp=%b", name, m_err, exp_err);
        end
        if (!drop_early) begin
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                m_addr = $urandom;
                @(negedge clk);
                total++;
                if ({m_ack, m_err, s_strb, s_sel, s_addr} !== {1'b1, exp_err, 4'h0, sel, addr}) begin
                    bad++;
                    $display("FAIL %s done_hold got ack=%b err=%b strb=%b sel=%0d a=%h exp ack=1 err=%b strb=0000 sel=%0d a=%h",
                             name, m_ack, m_err, s_strb, s_sel, s_addr, exp_err, sel, addr);
                end
            end
            m_req = 1'b0;
        end
        s_ack = 4'h0;
        @(negedge clk);
        total++;
        if ({m_ack, m_err, s_strb} !== {1'b0, 1'b0, 4'h0}) begin
            bad++;
            $display("FAIL %s release got ack=%b err=%b strb=%b exp ack=0 err=0 strb=0000",
                     name, m_ack, m_err, s_strb);
        end
        total++;
        if ({s_sel, s_wr, s_addr, s_wdata} !== {sel, wr, addr, wdata}) begin
            bad++;
            $display("FAIL %s idle_hold got sel=%0d a=%h d=%h exp sel=%0d a=%h d=%h",
                     name, s_sel, s_addr, s_wdata, sel, addr, wdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; m_req = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; s_ack = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({m_ack, m_err, s_sel, s_strb, s_wr, s_addr, s_wdata, dbg_state} !== 75'd0) begin
            bad++;
            $display("FAIL reset got ack=%b err=%b sel=%0d strb=%b wr=%b a=%h d=%h st=%0d exp all 0",
                     m_ack, m_err, s_sel, s_strb, s_wr, s_addr, s_wdata, dbg_state);
        end
    endtask

    task automatic test_directed();
        run_txn(32'h4000_0010, 1'b0, 32'h0, 1, 1'b0, 1'b0, "read_s1");
        run_txn(32'hC000_0000, 1'b1, 32'hDEAD_BEEF, 5, 1'b0, 1'b0, "write_s3");
        run_txn(32'h8000_0040, 1'b0, 32'h0, 0, 1'b1, 1'b0, "timeout_s2");
        run_txn(32'h8000_0044, 1'b1, 32'h1234_5678, T, 1'b1, 1'b0, "ack_last");
        run_txn(32'h0000_0100, 1'b0, 32'h0, T + 1, 1'b0, 1'b0, "ack_late");
        run_txn(32'h4000_0200, 1'b1, 32'hCAFE_F00D, 3, 1'b0, 1'b1, "drop_early");
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        m_req = 1'b1; m_addr = 32'h8000_0000; m_wr = 1'b1; m_wdata = 32'hA5A5_5A5A; s_ack = 4'h0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            total++;
            if (s_strb !== 4'b0100) begin
                bad++;
                $display("FAIL mid_reset_strobe idx=%0d got=%b exp=0100", n, s_strb);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({m_ack, m_err, s_sel, s_strb, s_wr, s_addr, s_wdata} !== 73'd0) begin
            bad++;
            $display("FAIL mid_reset got ack=%b strb=%b sel=%0d a=%h exp all 0", m_ack, s_strb, s_sel, s_addr);
        end
        reset = 1'b0;
        m_req = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            total++;
            if ({m_ack, s_strb} !== 5'd0) begin
                bad++;
                $display("FAIL mid_reset_quiet got ack=%b strb=%b exp ack=0 strb=0000", m_ack, s_strb);
            end
        end
        run_txn(32'h0000_0008, 1'b0, 32'h0, 2, 1'b0, 1'b0, "after_reset_s0");
    endtask

    task automatic test_back_to_back();
        run_txn(32'h0000_0004, 1'b1, 32'h1111_1111, $urandom_range(1, 4), 1'b1, 1'b0, "b2b_s0");
        run_txn(32'hC000_0008, 1'b0, 32'h0, $urandom_range(1, 4), 1'b1, 1'b0, "b2b_s3");
        run_txn(32'h4000_000C, 1'b1, 32'h3333_3333, $urandom_range(1, 4), 1'b1, 1'b0, "b2b_s1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_txn($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, T + 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_slave_decoder.md
# bus_slave_decoder

Master-side request decoder for the four-slave DLX data bus. It accepts one request at a time from the CPU memory stage and decodes address bits [31:30] to a one-hot slave strobe. It registers address, write data and direction toward the slaves, waits for the selected slave's acknowledge, and returns a four-phase acknowledge to the master, or a bus error after a bounded wait. Its registered `s_sel` output drives the select of the read-data return multiplexer. That select is held stable for the whole transaction, so read data stays valid while `m_ack` is high.

## Interface
- `TIMEOUT`, default 15: maximum number of strobe cycles before bus error; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `m_req` in 1: master request level, held until `m_ack`.
- `m_wr` in 1: 1 = write, 0 = read; sampled with `m_req`.
- `m_addr` in 32: byte address; [31:30] selects the slave.
- `m_wdata` in 32: write data; sampled with `m_req`.
- `m_ack` out 1: transaction complete, level, held until `m_req` drops.
- `m_err` out 1: bus error (timeout); valid while `m_ack` is high.
- `s_sel` out 2: latched slave index; drives the read-data mux select.
- `s_strb` out 4: one-hot slave strobe.
- `s_wr` out 1: latched direction.
- `s_addr` out 32: latched address.
- `s_wdata` out 32: latched write data.
- `s_ack` in 4: per-slave acknowledge; bit n from slave n.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - `s_strb`=0, `m_ack`=0.
  - When `m_req`=1 at the clock edge: latch `m_addr`, `m_wdata`, `m_wr` into `s_addr`/`s_wdata`/`s_wr`; set `s_sel` = `m_addr[31:30]`; clear the wait counter; go to ACCESS.
- ACCESS:
  - `s_strb[s_sel]`=1, all other strobe bits 0.
  - At each edge with `s_ack[s_sel]`=1: go to DONE, `m_ack`=1, `m_err`=0.
  - Otherwise the wait counter increments. When counter == TIMEOUT-1 and there is no ack: go to DONE, `m_ack`=1, `m_err`=1.
- DONE:
  - `s_strb`=0; `m_ack` held at 1 and `m_err` held.
  - When `m_req`=0 at an edge: go to IDLE, clear `m_ack` and `m_err`.
- `s_ack` bits of non-selected slaves are ignored in every state. `s_ack` seen in IDLE or DONE is ignored.
- `s_sel`, `s_addr`, `s_wdata`, `s_wr` change only on the IDLE→ACCESS edge. They hold their values through DONE and in IDLE until the next request.
- Master inputs are ignored outside IDLE. If `m_req` drops during ACCESS, the transaction still completes normally. DONE then sees `m_req`=0 and `m_ack` is high for exactly one cycle.
- Wait counter is 8 bits wide; it never wraps because TIMEOUT ≤ 255.

## Timing
- Reset (synchronous, at the edge with `reset`=1): state IDLE; `m_ack`=0, `m_err`=0, `s_strb`=0, `s_sel`=0, `s_wr`=0, `s_addr`=0, `s_wdata`=0, counter=0.
- Reset overrides any state, including mid-ACCESS: the strobe drops in the cycle after the reset edge, and no `m_ack` is produced.
- Latency, with `m_req` sampled at edge E0:
  - `s_strb` is high from E0 to E1.
  - If the slave acks in the first strobe cycle (sampled at E1), `m_ack` rises after E1. Minimum request-to-ack latency is 2 edges.
  - A slave ack sampled at edge Ek gives `m_ack` high after Ek.
  - On timeout, `s_strb` is high for exactly TIMEOUT cycles, and `m_ack`/`m_err` rise after edge E_TIMEOUT.
- Ack and timeout in the same cycle: the ack wins, with `m_err`=0.
- The earliest next request is sampled at the edge after IDLE is re-entered, so there is at least one idle cycle with `s_strb`=0 between transactions.

## Test plan
- Reset, then a read to 0x4000_0010 with slave 1 acking in its first strobe cycle:
  - `s_sel`=01, `s_strb`=0010 for 1 cycle, `s_wr`=0.
  - `m_ack`=1 with `m_err`=0 two edges after the request.
  - `m_ack` falls one edge after `m_req` drops.
- Write 0xDEADBEEF to 0xC000_0000, slave 3 acks after 4 wait cycles:
  - `s_wdata`=0xDEADBEEF, `s_wr`=1, `s_strb`=1000 for 5 cycles.
  - `m_ack`=1, `m_err`=0.
- Request to slave 2 with TIMEOUT=15 and no ack (other slaves hold `s_ack`=1):
  - `s_strb`=0100 for exactly 15 cycles.
  - `m_ack`=1, `m_err`=1.
  - Acks from non-selected slaves have no effect.
- Ack arriving in the last allowed cycle (cycle 15) → `m_err`=0.
- Reset asserted during the third cycle of ACCESS:
  - All outputs are 0 after the next edge and no `m_ack` is seen.
  - A new request to slave 0 afterwards completes normally.
- Back-to-back requests to slaves 0, 3, 1 with `m_addr` changing while `m_ack` is high:
  - `s_sel` is stable through each DONE.
  - Each transaction decodes only the address latched in IDLE.
